// File: rtl/mem_port_arbiter.sv
// Arbitrates one RAM read/write port between instruction fetch (IF) and load/store (LS),
// issuing registered RAM commands and routing each read return back to its issuer.

// Per-requester read return register: captures RAM data when a tagged read retires.
module mem_port_ret (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hit,
  input  logic [31:0] ram_data,
  output logic        rvalid,
  output logic [31:0] rdata
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= hit;
      if (hit) rdata <= ram_data;
    end
  end
endmodule

module mem_port_arbiter #(
  parameter int RD_LATENCY  = 1,
  parameter int LS_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        rd_ram_en,
  output logic [31:0] rd_ram_addr,
  input  logic [31:0] rd_ram_data,
  output logic        wr_ram_en,
  output logic [31:0] wr_ram_addr,
  output logic [31:0] wr_ram_data
);
  localparam int NUM_REQ = 2;
  localparam int REQ_IF  = 0;
  localparam int REQ_LS  = 1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic                             last_owner;   // 0 = IF, 1 = LS
  logic [NUM_REQ-1:0]               gnt;
  logic [NUM_REQ-1:0]               hit;
  logic [NUM_REQ-1:0]               rvalid;
  logic [NUM_REQ-1:0][31:0]         rdata;
  cmd_t                             gcmd;
  logic                             rd_go, wr_go;
  // Stage 0 is the cycle the RAM sees the read; stage RD_LATENCY is when its data is on the bus.
  logic [RD_LATENCY:0]              vld_pipe;
  logic [RD_LATENCY:0]              own_pipe;
  logic                             wr_en_q;
  logic [31:0]                      rd_addr_q, wr_addr_q, wr_data_q;

  // Grants are masked while reset is asserted so they drop immediately with it.
  always_comb begin
    gnt = '0;
    if (reset_n) begin
      if (if_req && ls_req) begin
        if (LS_PRIORITY != 0 || last_owner == 1'b0) gnt[REQ_LS] = 1'b1;
        else                                        gnt[REQ_IF] = 1'b1;
      end else begin
        gnt[REQ_IF] = if_req;
        gnt[REQ_LS] = ls_req;
      end
    end
  end

  always_comb begin
    gcmd = gnt[REQ_LS] ? cmd_t'{we: ls_we, addr: ls_addr, wdata: ls_wdata}
                       : cmd_t'{we: 1'b0, addr: if_addr, wdata: 32'h0};
    rd_go = (|gnt) && !gcmd.we;
    wr_go = (|gnt) && gcmd.we;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner <= 1'b0;
      vld_pipe   <= '0;
      own_pipe   <= '0;
      wr_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      if (|gnt) last_owner <= gnt[REQ_LS];
      vld_pipe[0] <= rd_go;
      own_pipe[0] <= gnt[REQ_LS];
      for (int i = 1; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        own_pipe[i] <= own_pipe[i-1];
      end
      wr_en_q <= wr_go;
      if (rd_go) rd_addr_q <= gcmd.addr;
      if (wr_go) begin
        wr_addr_q <= gcmd.addr;
        wr_data_q <= gcmd.wdata;
      end
    end
  end

  assign hit[REQ_IF] = vld_pipe[RD_LATENCY] && !own_pipe[RD_LATENCY];
  assign hit[REQ_LS] = vld_pipe[RD_LATENCY] &&  own_pipe[RD_LATENCY];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_ret
    mem_port_ret u_ret (
      .clk      (clk),
      .reset_n  (reset_n),
      .hit      (hit[r]),
      .ram_data (rd_ram_data),
      .rvalid   (rvalid[r]),
      .rdata    (rdata[r])
    );
  end

  assign if_gnt      = gnt[REQ_IF];
  assign ls_gnt      = gnt[REQ_LS];
  assign if_rvalid   = rvalid[REQ_IF];
  assign if_rdata    = rdata[REQ_IF];
  assign ls_rvalid   = rvalid[REQ_LS];
  assign ls_rdata    = rdata[REQ_LS];
  assign rd_ram_en   = vld_pipe[0];
  assign rd_ram_addr = rd_addr_q;
  assign wr_ram_en   = wr_en_q;
  assign wr_ram_addr = wr_addr_q;
  assign wr_ram_data = wr_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: u0 (latency 1, round-robin), u1 (latency 1, LS priority), u2 (latency 3, round-robin).
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;

  logic        if_gnt[3], if_rvalid[3], ls_gnt[3], ls_rvalid[3], rd_en[3], wr_en[3];
  logic [31:0] if_rdata[3], ls_rdata[3], rd_addr[3], rd_data[3], wr_addr[3], wr_data[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ramf(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  mem_port_arbiter #(.RD_LATENCY(1), .LS_PRIORITY(0)) u0 (
    .clk(clk), .reset_n(reset_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]), .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt[0]), .ls_rvalid(ls_rvalid[0]),
    .ls_rdata(ls_rdata[0]), .rd_ram_en(rd_en[0]), .rd_ram_addr(rd_addr[0]),
    .rd_ram_data(rd_data[0]), .wr_ram_en(wr_en[0]), .wr_ram_addr(wr_addr[0]),
    .wr_ram_data(wr_data[0]));

  mem_port_arbiter #(.RD_LATENCY(1), .LS_PRIORITY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]), .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt[1]), .ls_rvalid(ls_rvalid[1]),
    .ls_rdata(ls_rdata[1]), .rd_ram_en(rd_en[1]), .rd_ram_addr(rd_addr[1]),
    .rd_ram_data(rd_data[1]), .wr_ram_en(wr_en[1]), .wr_ram_addr(wr_addr[1]),
    .wr_ram_data(wr_data[1]));

  mem_port_arbiter #(.RD_LATENCY(3), .LS_PRIORITY(0)) u2 (
    .clk(clk), .reset_n(reset_n), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt[2]),
    .if_rvalid(if_rvalid[2]), .if_rdata(if_rdata[2]), .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt[2]), .ls_rvalid(ls_rvalid[2]),
    .ls_rdata(ls_rdata[2]), .rd_ram_en(rd_en[2]), .rd_ram_addr(rd_addr[2]),
    .rd_ram_data(rd_data[2]), .wr_ram_en(wr_en[2]), .wr_ram_addr(wr_addr[2]),
    .wr_ram_data(wr_data[2]));

  // RAM model: data for a read seen in cycle C1 is on the bus during cycle C1+latency.
  logic [31:0] ramq[3][4];
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      ramq[u][0] <= rd_en[u] ? ramf(rd_addr[u]) : 32'h0BAD_0BAD;
      for (int i = 1; i < 4; i++) ramq[u][i] <= ramq[u][i-1];
    end
  end
  assign rd_data[0] = ramq[0][0];
  assign rd_data[1] = ramq[1][0];
  assign rd_data[2] = ramq[2][2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                     input logic [31:0] la, input logic [31:0] lwd);
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = lwd;
  endtask

  typedef struct {
    logic        if_req;  logic [31:0] if_addr;
    logic        ls_req;  logic ls_we; logic [31:0] ls_addr; logic [31:0] ls_wdata;
    logic        e_if_gnt, e_ls_gnt;
    logic        e_rd_en; logic [31:0] e_rd_addr;
    logic        e_wr_en; logic [31:0] e_wr_addr; logic [31:0] e_wr_data;
    logic        e_if_rv; logic [31:0] e_if_rd;
    logic        e_ls_rv; logic [31:0] e_ls_rd;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
    input logic [31:0] la, input logic [31:0] lwd,
    input logic gi, input logic gl, input logic re, input logic [31:0] ra,
    input logic we, input logic [31:0] wa, input logic [31:0] wd,
    input logic iv, input logic [31:0] id, input logic lv, input logic [31:0] ld);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw; v.ls_addr = la; v.ls_wdata = lwd;
    v.e_if_gnt = gi; v.e_ls_gnt = gl; v.e_rd_en = re; v.e_rd_addr = ra;
    v.e_wr_en = we; v.e_wr_addr = wa; v.e_wr_data = wd;
    v.e_if_rv = iv; v.e_if_rd = id; v.e_ls_rv = lv; v.e_ls_rd = ld;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    // u0 table: IF stream, 4-cycle conflict (LS,IF,LS,IF), then an LS write.
    tbl[0]  = mk(1,32'h0,  0,0,32'h0,  0, 1,0, 0,0,          0,0,0, 0,0,              0,0);
    tbl[1]  = mk(1,32'h4,  0,0,32'h0,  0, 1,0, 1,32'h0,      0,0,0, 0,0,              0,0);
    tbl[2]  = mk(1,32'h8,  0,0,32'h0,  0, 1,0, 1,32'h4,      0,0,0, 0,0,              0,0);
    tbl[3]  = mk(0,32'h0,  0,0,32'h0,  0, 0,0, 1,32'h8,      0,0,0, 1,ramf(32'h0),    0,0);
    tbl[4]  = mk(0,32'h0,  0,0,32'h0,  0, 0,0, 0,0,          0,0,0, 1,ramf(32'h4),    0,0);
    tbl[5]  = mk(1,32'h10, 1,0,32'h200,0, 0,1, 0,0,          0,0,0, 1,ramf(32'h8),    0,0);
    tbl[6]  = mk(1,32'h10, 1,0,32'h204,0, 1,0, 1,32'h200,    0,0,0, 0,0,              0,0);
    tbl[7]  = mk(1,32'h14, 1,0,32'h204,0, 0,1, 1,32'h10,     0,0,0, 0,0,              0,0);
    tbl[8]  = mk(1,32'h14, 1,0,32'h208,0, 1,0, 1,32'h204,    0,0,0, 0,0,              1,ramf(32'h200));
    tbl[9]  = mk(0,32'h0,  1,1,32'h100,32'hDEADBEEF, 0,1, 1,32'h14, 0,0,0, 1,ramf(32'h10), 0,0);
    tbl[10] = mk(0,32'h0,  0,0,32'h0,  0, 0,0, 0,0, 1,32'h100,32'hDEADBEEF, 0,0,     1,ramf(32'h204));
    tbl[11] = mk(0,32'h0,  0,0,32'h0,  0, 0,0, 0,0,          0,0,0, 1,ramf(32'h14),   0,0);
    tbl[12] = mk(0,32'h0,  0,0,32'h0,  0, 0,0, 0,0,          0,0,0, 0,0,              0,0);
    tbl[13] = mk(0,32'h0,  0,0,32'h0,  0, 0,0, 0,0,          0,0,0, 0,0,              0,0);

    // Asynchronous reset mid-cycle with a read in flight.
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1 drv(1,32'h80,0,0,0,0);
    @(negedge clk);
    chk("pre-reset if_gnt", 32'(if_gnt[0]), 1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("reset if_gnt", 32'(if_gnt[0]), 0);
    chk("reset rd_ram_en", 32'(rd_en[0]), 0);
    chk("reset rd_ram_addr", rd_addr[0], 0);
    chk("reset wr_ram_en", 32'(wr_en[0]), 0);
    chk("reset rvalid", {30'h0, if_rvalid[0], ls_rvalid[0]}, 0);
    drv(0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; drv(1,32'h84,1,0,32'h284,0);
    #1;
    chk("first conflict goes LS", {30'h0, if_gnt[0], ls_gnt[0]}, 32'h1);
    drv(0,0,0,0,0,0);

    for (int t = 0; t < 14; t++) begin
      @(posedge clk);
      #1 drv(tbl[t].if_req, tbl[t].if_addr, tbl[t].ls_req, tbl[t].ls_we, tbl[t].ls_addr, tbl[t].ls_wdata);
      @(negedge clk);
      chk($sformatf("v%0d if_gnt", t), 32'(if_gnt[0]), 32'(tbl[t].e_if_gnt));
      chk($sformatf("v%0d ls_gnt", t), 32'(ls_gnt[0]), 32'(tbl[t].e_ls_gnt));
      chk($sformatf("v%0d rd_ram_en", t), 32'(rd_en[0]), 32'(tbl[t].e_rd_en));
      chk($sformatf("v%0d wr_ram_en", t), 32'(wr_en[0]), 32'(tbl[t].e_wr_en));
      chk($sformatf("v%0d if_rvalid", t), 32'(if_rvalid[0]), 32'(tbl[t].e_if_rv));
      chk($sformatf("v%0d ls_rvalid", t), 32'(ls_rvalid[0]), 32'(tbl[t].e_ls_rv));
      if (tbl[t].e_rd_en) chk($sformatf("v%0d rd_ram_addr", t), rd_addr[0], tbl[t].e_rd_addr);
      if (tbl[t].e_wr_en) begin
        chk($sformatf("v%0d wr_ram_addr", t), wr_addr[0], tbl[t].e_wr_addr);
        chk($sformatf("v%0d wr_ram_data", t), wr_data[0], tbl[t].e_wr_data);
      end
      if (tbl[t].e_if_rv) chk($sformatf("v%0d if_rdata", t), if_rdata[0], tbl[t].e_if_rd);
      if (tbl[t].e_ls_rv) chk($sformatf("v%0d ls_rdata", t), ls_rdata[0], tbl[t].e_ls_rd);
    end

    // LS priority (u1): LS wins three conflicts, IF gets in once LS drops.
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 drv(1,32'h20,1,0,32'h400 + 32'(c*4),0);
      @(negedge clk);
      chk($sformatf("prio c%0d ls_gnt", c), 32'(ls_gnt[1]), 1);
      chk($sformatf("prio c%0d if_gnt", c), 32'(if_gnt[1]), 0);
      if (c == 1) chk("rr c1 if_gnt", 32'(if_gnt[0]), 1);
    end
    @(posedge clk); #1 drv(1,32'h20,0,0,0,0);
    @(negedge clk);
    chk("prio c3 if_gnt", 32'(if_gnt[1]), 1);
    chk("prio c3 ls_gnt", 32'(ls_gnt[1]), 0);
    @(posedge clk); #1 drv(0,0,0,0,0,0);

    // Reset while two reads are in flight (u2, latency 3).
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1 drv(1,32'h30,1,0,32'h300,0);
    @(negedge clk);
    chk("flight g0 ls_gnt", 32'(ls_gnt[2]), 1);
    @(posedge clk); #1 drv(1,32'h30,0,0,0,0);
    @(negedge clk);
    chk("flight g1 if_gnt", 32'(if_gnt[2]), 1);
    @(posedge clk); #1 drv(0,0,0,0,0,0);
    @(posedge clk); #2 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("flushed c%0d rvalid", c), {30'h0, if_rvalid[2], ls_rvalid[2]}, 0);
    end
    @(posedge clk); #1 drv(1,32'h40,0,0,0,0);
    @(negedge clk);
    chk("post-reset if_gnt", 32'(if_gnt[2]), 1);
    @(posedge clk); #1 drv(0,0,0,0,0,0);
    @(negedge clk);
    chk("post-reset rd_ram_en", 32'(rd_en[2]), 1);
    chk("post-reset rd_ram_addr", rd_addr[2], 32'h40);
    repeat (3) @(negedge clk);
    chk("post-reset early if_rvalid", 32'(if_rvalid[2]), 0);
    @(negedge clk);
    chk("post-reset if_rvalid", 32'(if_rvalid[2]), 1);
    chk("post-reset if_rdata", if_rdata[2], ramf(32'h40));
    chk("post-reset ls_rvalid", 32'(ls_rvalid[2]), 0);
    @(negedge clk);
    chk("post-reset if_rvalid single", 32'(if_rvalid[2]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the execution unit's single RAM read/write port between two requesters: instruction fetch (IF) and load/store (LS). Each cycle it grants at most one request and drives the RAM command. It tracks in-flight reads and returns each read's data to the requester that issued it. It sits between the fetch/LS logic of exec_unit and the RAM.

Parameters:
RD_LATENCY, 1, RAM read latency in cycles (legal 1..4); rd_ram_data is valid RD_LATENCY cycles after the cycle rd_ram_en is high
LS_PRIORITY, 0, 0 = round-robin on conflict; 1 = LS always wins on conflict

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
if_req  in  1  IF read request; held until granted
if_addr  in  32  IF read address
if_gnt  out  1  IF request accepted this cycle (combinational)
if_rvalid  out  1  IF read data valid (registered)
if_rdata  out  32  IF read data
ls_req  in  1  LS request; held until granted
ls_we  in  1  1 = write, 0 = read
ls_addr  in  32  LS address
ls_wdata  in  32  LS write data
ls_gnt  out  1  LS request accepted this cycle (combinational)
ls_rvalid  out  1  LS read data valid (registered)
ls_rdata  out  32  LS read data
rd_ram_en  out  1  RAM read strobe (registered)
rd_ram_addr  out  32  RAM read address
rd_ram_data  in  32  RAM read data
wr_ram_en  out  1  RAM write strobe (registered)
wr_ram_addr  out  32  RAM write address
wr_ram_data  out  32  RAM write data

Behaviour:
- Reset is asynchronous and active-low, on reset_n. While reset_n=0, all registered outputs are 0, the in-flight tracking pipe is cleared and last_owner=IF.
- Grant, same cycle as the request (combinational):
  - Only one requester active: that requester is granted.
  - Both active, LS_PRIORITY=1: LS is granted.
  - Both active, LS_PRIORITY=0: the requester other than last_owner is granted.
  - last_owner updates on every grant.
  - At most one of if_gnt/ls_gnt is high per cycle. A gnt is never high without its req.
- Command issue: at the clock edge that ends the grant cycle (C0), the command is registered, so the RAM sees it during C1.
  - IF grant, or LS read grant: rd_ram_en=1, rd_ram_addr=granted address.
  - LS write grant: wr_ram_en=1, wr_ram_addr=ls_addr, wr_ram_data=ls_wdata.
  - The strobe is 1 for exactly one cycle per grant. Both strobes are 0 in cycles with no grant. rd_ram_en and wr_ram_en are never high together.
- Read return:
  - An owner tag shift pipe of depth RD_LATENCY records the owner of each read.
  - rd_ram_data is sampled in cycle C1+RD_LATENCY and registered into the owner's rdata.
  - The owner's rvalid is high for exactly one cycle, C2+RD_LATENCY. For RD_LATENCY=1, data returns 3 cycles after the grant cycle.
  - The non-owner's rvalid stays 0 and its rdata holds its previous value.
- Writes produce no rvalid; ls_gnt is the write acknowledge.
- Throughput: one grant per cycle with no bubbles. Up to RD_LATENCY+1 reads may be in flight.
- Per-requester order: data returns in grant order. Interleaved owners are routed correctly.
- Requests are ungated: new grants are issued while reads are in flight, because the return path is fully pipelined.
- Reset mid-operation: in-flight reads are dropped, no rvalid fires after reset deasserts, and the pipe restarts empty.
- Address and data pass through unchanged at full 32 bits. No alignment check; alignment is the requesters' job.

Test Plan:
- Reset: reset_n=0 asserted asynchronously mid-cycle → all strobes, gnt and rvalid outputs go to 0 immediately; last_owner=IF.
- IF-only reads (RD_LATENCY=1): if_req=1, if_addr=0x0,0x4,0x8 on consecutive cycles → if_gnt=1 every cycle; rd_ram_en high in C1..C3 with addresses 0x0/0x4/0x8; if_rvalid high in C3..C5 carrying the RAM model's data for each address in order.
- Conflict, round-robin: if_req=ls_req=1 for 4 cycles, ls_we=0 → grants LS, IF, LS, IF (first conflict after reset goes to LS); returned data routed to the correct requester each cycle.
- Conflict with LS_PRIORITY=1: both requesting for 3 cycles → ls_gnt all 3 cycles, if_gnt=0; IF is granted on the 4th cycle after ls_req drops.
- LS write: ls_req=1, ls_we=1, ls_addr=0x100, ls_wdata=0xDEADBEEF → ls_gnt=1; next cycle wr_ram_en=1, wr_ram_addr=0x100, wr_ram_data=0xDEADBEEF, rd_ram_en=0; no ls_rvalid.
- Reset during flight (RD_LATENCY=3): two reads granted, reset_n pulsed low before return → no if_rvalid or ls_rvalid pulses afterwards; a new read after reset returns normally 5 cycles after its grant.
